// File: rtl/seg_scan_driver.sv
// Multiplexed multi-digit 7-segment driver: shadowed nibble word, hex/dash glyphs,
// per-digit decimal points, leading-zero blanking and selectable pin polarity.
module seg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  input  logic                  hex_en,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;

  logic [3:0]          nibble;
  logic                dp_bit;
  logic                blank;
  logic [DIGITS-1:0]   blank_vec;
  logic [DIGITS-1:0]   onehot;
  logic [6:0]          glyph;
  logic [7:0]          seg_logical;
  logic                run;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_val <= value;
      shadow_dp  <= dp_mask;
    end
  end

  // Each digit stays selected for SCAN_DIV cycles; index advances on terminal count.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Blanking runs from the top digit down and stops at the first non-zero nibble or set dp.
  always_comb begin
    blank_vec = '0;
    run       = BLANK_LEADING;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (shadow_val[4*i +: 4] != 4'h0 || shadow_dp[i]) run = 1'b0;
      blank_vec[i] = run && (i != 0);
    end
  end

  always_comb begin
    nibble = 4'h0;
    dp_bit = 1'b0;
    blank  = 1'b0;
    onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) begin
        nibble    = shadow_val[4*i +: 4];
        dp_bit    = shadow_dp[i];
        blank     = blank_vec[i];
        onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    glyph = 7'b0000000;
    case (nibble)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      4'hF: glyph = 7'b1110001;
      default: glyph = 7'b0000000;
    endcase
    if (nibble >= 4'hA && !hex_en) glyph = 7'b1000000;
    seg_logical = blank ? 8'h00 : {dp_bit, glyph};
  end

  // seg and dig_sel share one register stage so the glyph never lags its digit enable.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= {8{SEG_ACTIVE_LOW}};
      dig_sel <= {DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      seg     <= seg_logical ^ {8{SEG_ACTIVE_LOW}};
      dig_sel <= onehot ^ {DIGITS{DIG_ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: scan walk, glyphs, blanking, polarity and async reset.
module tb_seg_scan_driver;

  logic        clock;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        load;
  logic        hex_en;
  logic [7:0]  seg_m, seg_i, seg_o;
  logic [3:0]  dig_m, dig_i;
  logic        dig_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    int         unit;
    logic [3:0] dig;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0),
                    .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_main (
    .clock(clock), .rst_n(rst_n), .value(value), .dp_mask(dp_mask),
    .load(load), .hex_en(hex_en), .seg(seg_m), .dig_sel(dig_m));

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1),
                    .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_inv (
    .clock(clock), .rst_n(rst_n), .value(value), .dp_mask(dp_mask),
    .load(load), .hex_en(hex_en), .seg(seg_i), .dig_sel(dig_i));

  seg_scan_driver #(.DIGITS(1), .SCAN_DIV(3), .SEG_ACTIVE_LOW(1'b0),
                    .DIG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_one (
    .clock(clock), .rst_n(rst_n), .value(value[3:0]), .dp_mask(dp_mask[0]),
    .load(load), .hex_en(hex_en), .seg(seg_o), .dig_sel(dig_o));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  task automatic push_exp(input string tag, input int unit, input logic [3:0] dig,
                          input logic [7:0] segv);
    exp_t e;
    e.tag  = tag;
    e.unit = unit;
    e.dig  = dig;
    e.seg  = segv;
    sb.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value   = v;
    dp_mask = d;
    load    = 1'b1;
    @(negedge clock);
    load    = 1'b0;
    @(negedge clock);
  endtask

  // Pops each expectation, waits (bounded) for its digit to be selected, then compares seg.
  task automatic drain();
    exp_t       e;
    logic       found;
    logic [3:0] d;
    logic [7:0] s;
    while (sb.size() > 0) begin
      e     = sb.pop_front();
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
        d = (e.unit == 0) ? dig_m : dig_i;
        if (d === e.dig) begin
          found = 1'b1;
          break;
        end
        @(negedge clock);
      end
      total++;
      assert (found)
        else begin
          bad++;
          $error("FAIL %s_timeout observed=%h expected=%h", e.tag, d, e.dig);
        end
      if (found) begin
        s = (e.unit == 0) ? seg_m : seg_i;
        chk(e.tag, s, e.seg);
      end
    end
  endtask

  initial begin
    logic [3:0] wexp;
    logic       hit;
    rst_n   = 1'b0;
    value   = 16'h0000;
    dp_mask = 4'b0000;
    load    = 1'b0;
    hex_en  = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_seg", seg_m, 8'h00);
    chk("rst_dig", {4'h0, dig_m}, 8'h0F);
    chk("rst_seg_inv", seg_i, 8'hFF);
    chk("rst_dig_one", {7'h0, dig_o}, 8'h01);

    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clock);
      wexp = ~(4'b0001 << ((n - 1) / 4));
      chk($sformatf("walk%0d", n), {4'h0, dig_m}, {4'h0, wexp});
    end
    chk("one_digit_sel", {7'h0, dig_o}, 8'h00);

    do_load(16'h1234, 4'b0100);
    push_exp("d0_4", 0, 4'b1110, 8'h66);
    push_exp("d1_3", 0, 4'b1101, 8'h4F);
    push_exp("d2_2dp", 0, 4'b1011, 8'hDB);
    push_exp("d3_1", 0, 4'b0111, 8'h06);
    drain();

    hex_en = 1'b1;
    do_load(16'h00A0, 4'b0000);
    push_exp("a_d0", 0, 4'b1110, 8'h3F);
    push_exp("a_d1_hex", 0, 4'b1101, 8'h77);
    push_exp("a_d2_blank", 0, 4'b1011, 8'h00);
    push_exp("a_d3_blank", 0, 4'b0111, 8'h00);
    drain();
    hex_en = 1'b0;
    @(negedge clock);
    push_exp("a_d1_dash", 0, 4'b1101, 8'h40);
    drain();
    hex_en = 1'b1;

    do_load(16'h0000, 4'b0000);
    push_exp("z_d0", 0, 4'b1110, 8'h3F);
    push_exp("z_d1", 0, 4'b1101, 8'h00);
    push_exp("z_d2", 0, 4'b1011, 8'h00);
    push_exp("z_d3", 0, 4'b0111, 8'h00);
    drain();
    do_load(16'h0000, 4'b1000);
    push_exp("zdp_d3", 0, 4'b0111, 8'hBF);
    push_exp("zdp_d0", 0, 4'b1110, 8'h3F);
    push_exp("zdp_d1", 0, 4'b1101, 8'h3F);
    push_exp("zdp_d2", 0, 4'b1011, 8'h3F);
    drain();

    do_load(16'h0008, 4'b0001);
    push_exp("inv_d0_8dp", 1, 4'b1110, 8'h00);
    push_exp("inv_d1_blank", 1, 4'b1101, 8'hFF);
    push_exp("m_d0_8dp", 0, 4'b1110, 8'hFF);
    push_exp("m_d1_blank", 0, 4'b1101, 8'h00);
    drain();

    value   = 16'h5555;
    dp_mask = 4'b0000;
    repeat (3) @(negedge clock);
    push_exp("noload_hold", 0, 4'b1110, 8'hFF);
    drain();

    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (dig_m === 4'b1011) begin
        hit = 1'b1;
        break;
      end
      @(negedge clock);
    end
    total++;
    assert (hit)
      else begin
        bad++;
        $error("FAIL midscan_wait observed=%h expected=%h", dig_m, 4'b1011);
      end
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", seg_m, 8'h00);
    chk("async_dig", {4'h0, dig_m}, 8'h0F);
    chk("async_seg_inv", seg_i, 8'hFF);
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("restart_dig", {4'h0, dig_m}, 8'h0E);
    chk("restart_seg", seg_m, 8'h3F);
    push_exp("restart_d1", 0, 4'b1101, 8'h00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
